// File: rtl/camera_capture.sv
// camera_capture: captures frames from a parallel 8-bit camera bus into
// frame-buffer writes. The camera signals are sampled as data on clk, so no
// second clock domain is created.
//
// Ports
//   clk          system clock; all logic runs on its rising edge
//   reset        synchronous, active-high reset
//   vsync        raw camera vsync, high during vertical blank
//   href         raw camera line-valid
//   pclk         raw camera pixel clock, at most clk/4
//   data_in      raw camera byte
//   arm          capture request, honoured in IDLE only
//   continuous   re-arm after each frame; sampled when a frame ends
//   data_out     packed pixel; first byte is most significant
//   pixel_valid  one-cycle strobe qualifying data_out / pixel_addr
//   pixel_addr   frame-buffer address of the pixel
//   frame_done   one-cycle end-of-frame pulse
//   busy         high whenever the FSM is not in IDLE
//   err_line     sticky: a line's byte count differed from H_PIXELS*BPP
//   err_frame    sticky: a frame's line count differed from V_LINES
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | waiting for arm
// S_WAIT_VS | armed, waiting for vsync to fall (frame start)
// S_CAPTURE | collecting pixels until vsync rises (frame end)
module camera_capture #(
  parameter int BPP        = 2,
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int DECIM_LOG2 = 0,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic              pclk,
  input  logic [7:0]        data_in,
  input  logic              arm,
  input  logic              continuous,
  output logic [31:0]       data_out,
  output logic              pixel_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              frame_done,
  output logic              busy,
  output logic              err_line,
  output logic              err_frame
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  localparam logic [15:0] H_L        = 16'(H_PIXELS);
  localparam logic [15:0] V_L        = 16'(V_LINES);
  localparam logic [15:0] LINE_BYTES = 16'(H_PIXELS * BPP);
  localparam logic [15:0] DMASK      = 16'((1 << DECIM_LOG2) - 1);
  localparam logic [15:0] H_DEC      = 16'(H_PIXELS >> DECIM_LOG2);
  localparam logic [1:0]  BYTE_LAST  = 2'(BPP - 1);

  // Counters saturate so an absurdly long line/frame cannot wrap back to a
  // "correct" looking count.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e state_q, state_d;

  // {vsync, href, pclk, data_in}
  logic [10:0] sync1_q, sync2_q;
  logic        vs_prev_q, href_prev_q, pclk_prev_q;

  logic [1:0]        byte_q, byte_d;
  logic [15:0]       col_q, col_d;
  logic [15:0]       line_q, line_d;
  logic [15:0]       lbytes_q, lbytes_d;
  logic [31:0]       pix_q, pix_d;

  logic [31:0]       data_q, data_d;
  logic              pv_q, pv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fd_q, fd_d;
  logic              errl_q, errl_d;
  logic              errf_q, errf_d;

  logic       vs_s, href_s, pclk_s;
  logic [7:0] d_s;
  logic       vs_rise, vs_fall, href_fall, pclk_rise;
  logic [31:0] addr_full;

  assign vs_s   = sync2_q[10];
  assign href_s = sync2_q[9];
  assign pclk_s = sync2_q[8];
  assign d_s    = sync2_q[7:0];

  assign vs_rise   =  vs_s   & ~vs_prev_q;
  assign vs_fall   = ~vs_s   &  vs_prev_q;
  assign href_fall = ~href_s &  href_prev_q;
  assign pclk_rise =  pclk_s & ~pclk_prev_q;

  assign addr_full = 32'(line_q >> DECIM_LOG2) * 32'(H_DEC) + 32'(col_q >> DECIM_LOG2);

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    col_d    = col_q;
    line_d   = line_q;
    lbytes_d = lbytes_q;
    pix_d    = pix_q;
    data_d   = data_q;
    pv_d     = 1'b0;
    addr_d   = addr_q;
    fd_d     = 1'b0;
    errl_d   = errl_q;
    errf_d   = errf_q;

    case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_WAIT_VS;
      end

      S_WAIT_VS: begin
        if (vs_fall) begin
          state_d  = S_CAPTURE;
          byte_d   = 2'd0;
          col_d    = 16'd0;
          line_d   = 16'd0;
          lbytes_d = 16'd0;
        end
      end

      S_CAPTURE: begin
        if (pclk_rise && href_s) begin
          lbytes_d = sat_inc(lbytes_q);
          // Starting a fresh pixel clears the upper bytes so bits above
          // 8*BPP stay zero.
          pix_d = (byte_q == 2'd0) ? {24'd0, d_s} : {pix_q[23:0], d_s};
          if (byte_q == BYTE_LAST) begin
            byte_d = 2'd0;
            col_d  = sat_inc(col_q);
            if (col_q < H_L && line_q < V_L &&
                (col_q & DMASK) == 16'd0 && (line_q & DMASK) == 16'd0) begin
              pv_d   = 1'b1;
              data_d = pix_d;
              addr_d = ADDR_W'(addr_full);
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end

        // href is already low here, so no byte can be captured this cycle.
        if (href_fall) begin
          if (lbytes_q != LINE_BYTES) errl_d = 1'b1;
          line_d   = sat_inc(line_q);
          col_d    = 16'd0;
          byte_d   = 2'd0;
          lbytes_d = 16'd0;
        end

        // Uses line_d so a coincident line end is counted first.
        if (vs_rise) begin
          fd_d    = 1'b1;
          if (line_d != V_L) errf_d = 1'b1;
          state_d = continuous ? S_WAIT_VS : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      pclk_prev_q <= 1'b0;
      byte_q      <= '0;
      col_q       <= '0;
      line_q      <= '0;
      lbytes_q    <= '0;
      pix_q       <= '0;
      data_q      <= '0;
      pv_q        <= 1'b0;
      addr_q      <= '0;
      fd_q        <= 1'b0;
      errl_q      <= 1'b0;
      errf_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= {vsync, href, pclk, data_in};
      sync2_q     <= sync1_q;
      vs_prev_q   <= vs_s;
      href_prev_q <= href_s;
      pclk_prev_q <= pclk_s;
      byte_q      <= byte_d;
      col_q       <= col_d;
      line_q      <= line_d;
      lbytes_q    <= lbytes_d;
      pix_q       <= pix_d;
      data_q      <= data_d;
      pv_q        <= pv_d;
      addr_q      <= addr_d;
      fd_q        <= fd_d;
      errl_q      <= errl_d;
      errf_q      <= errf_d;
    end
  end

  assign data_out    = data_q;
  assign pixel_valid = pv_q;
  assign pixel_addr  = addr_q;
  assign frame_done  = fd_q;
  assign busy        = (state_q != S_IDLE);
  assign err_line    = errl_q;
  assign err_frame   = errf_q;

endmodule

// File: tb/tb_camera_capture.sv
module tb_camera_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic        pclk = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        arm_a = 1'b0;
  logic        arm_b = 1'b0;
  logic        continuous = 1'b0;

  logic [31:0] dout_a, dout_b;
  logic        pv_a, pv_b, fd_a, fd_b, busy_a, busy_b;
  logic        errl_a, errl_b, errf_a, errf_b;
  logic [18:0] addr_a, addr_b;

  typedef struct packed {
    logic [18:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_cmp = 0;
  int n_fail = 0;
  int fdc_a = 0, fdc_b = 0;
  int pix_a = 0, pix_b = 0;
  bit overrun_a = 1'b0;

  always #5 clk = ~clk;

  camera_capture #(.BPP(2), .H_PIXELS(4), .V_LINES(2), .DECIM_LOG2(0), .ADDR_W(19)) dut_a (
    .clk(clk), .reset(reset), .vsync(vsync), .href(href), .pclk(pclk),
    .data_in(data_in), .arm(arm_a), .continuous(continuous),
    .data_out(dout_a), .pixel_valid(pv_a), .pixel_addr(addr_a),
    .frame_done(fd_a), .busy(busy_a), .err_line(errl_a), .err_frame(errf_a)
  );

  camera_capture #(.BPP(2), .H_PIXELS(4), .V_LINES(4), .DECIM_LOG2(1), .ADDR_W(19)) dut_b (
    .clk(clk), .reset(reset), .vsync(vsync), .href(href), .pclk(pclk),
    .data_in(data_in), .arm(arm_b), .continuous(continuous),
    .data_out(dout_b), .pixel_valid(pv_b), .pixel_addr(addr_b),
    .frame_done(fd_b), .busy(busy_b), .err_line(errl_b), .err_frame(errf_b)
  );

  // Advance n clocks; after each edge pop the scoreboard for any pixel seen.
  task automatic step(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pv_a) begin
        pix_a++;
        if (addr_a >= 19'd8) overrun_a = 1'b1;
        n_cmp++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a_unexpected: got addr=%0d data=%h, none expected", addr_a, dout_a);
        end else begin
          e = q_a.pop_front();
          if (addr_a !== e.addr || dout_a !== e.data) begin
            n_fail++;
            $display("FAIL sb_a_pixel: got addr=%0d data=%h, expected addr=%0d data=%h",
                     addr_a, dout_a, e.addr, e.data);
          end
        end
      end
      if (pv_b) begin
        pix_b++;
        n_cmp++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b_unexpected: got addr=%0d data=%h, none expected", addr_b, dout_b);
        end else begin
          e = q_b.pop_front();
          if (addr_b !== e.addr || dout_b !== e.data) begin
            n_fail++;
            $display("FAIL sb_b_pixel: got addr=%0d data=%h, expected addr=%0d data=%h",
                     addr_b, dout_b, e.addr, e.data);
          end
        end
      end
      if (fd_a) fdc_a++;
      if (fd_b) fdc_b++;
    end
  endtask

  // Reference model: which completed pixels each instance should emit.
  task automatic push_exp(input int tgt, input int line, input int col, input logic [31:0] d);
    exp_t e;
    e.data = d;
    if (tgt == 0) begin
      if (col < 4 && line < 2) begin
        e.addr = 19'(line * 4 + col);
        q_a.push_back(e);
      end
    end else begin
      if (col < 4 && line < 4 && col % 2 == 0 && line % 2 == 0) begin
        e.addr = 19'((line / 2) * 2 + col / 2);
        q_b.push_back(e);
      end
    end
  endtask

  task automatic send_bytes(input int tgt, input int line, input int nbytes, input int first);
    for (int i = 0; i < nbytes; i++) begin
      data_in = 8'(first + i);
      pclk = 1'b0;
      step(4);
      pclk = 1'b1;
      if (i % 2 == 1) push_exp(tgt, line, i / 2, {16'd0, 8'(first + i - 1), 8'(first + i)});
      step(4);
    end
    pclk = 1'b0;
    step(4);
  endtask

  task automatic send_line(input int tgt, input int line, input int nbytes, input int first);
    href = 1'b1;
    step(4);
    send_bytes(tgt, line, nbytes, first);
    href = 1'b0;
    step(6);
  endtask

  task automatic send_frame(input int tgt, input int nlines, input int nbytes);
    step(8);
    vsync = 1'b0;
    step(8);
    for (int l = 0; l < nlines; l++) send_line(tgt, l, nbytes, 1 + l * nbytes);
    vsync = 1'b1;
    step(10);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    href = 1'b0; pclk = 1'b0; vsync = 1'b1;
    arm_a = 1'b0; arm_b = 1'b0; continuous = 1'b0;
    step(2);
    reset = 1'b0;
    q_a.delete(); q_b.delete();
    fdc_a = 0; fdc_b = 0; pix_a = 0; pix_b = 0; overrun_a = 1'b0;
    step(4);
  endtask

  task automatic pulse_arm(input int tgt);
    if (tgt == 0) arm_a = 1'b1; else arm_b = 1'b1;
    step(1);
    arm_a = 1'b0; arm_b = 1'b0;
    step(1);
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d/%0d pixels still expected, required 0/0", name, q_a.size(), q_b.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (dout_a !== 32'd0 || pv_a !== 1'b0 || addr_a !== 19'd0 || fd_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: dout=%h pv=%b addr=%0d fd=%b, required all 0", dout_a, pv_a, addr_a, fd_a);
    end
    n_cmp++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || errl_a !== 1'b0 || errf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b/%b errl=%b errf=%b, required all 0", busy_a, busy_b, errl_a, errf_a);
    end
  endtask

  task automatic test_single_frame();
    apply_reset();
    pulse_arm(0);
    n_cmp++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_armed: got %b, required 1", busy_a); end
    send_frame(0, 2, 8);
    check_drained("single");
    n_cmp++;
    if (pix_a != 8 || fdc_a != 1) begin
      n_fail++;
      $display("FAIL single_counts: pixels=%0d frame_done=%0d, required 8 and 1", pix_a, fdc_a);
    end
    n_cmp++;
    if (errl_a !== 1'b0 || errf_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_status: errl=%b errf=%b busy=%b, required 0 0 0", errl_a, errf_a, busy_a);
    end
  endtask

  task automatic test_continuous();
    apply_reset();
    continuous = 1'b1;
    pulse_arm(0);
    send_frame(0, 2, 8);
    n_cmp++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL cont_busy_between: got %b, required 1", busy_a); end
    send_frame(0, 2, 8);
    n_cmp++;
    if (fdc_a != 2 || busy_a !== 1'b1 || pix_a != 16) begin
      n_fail++;
      $display("FAIL cont_two_frames: frame_done=%0d busy=%b pixels=%0d, required 2 1 16", fdc_a, busy_a, pix_a);
    end
    continuous = 1'b0;
    send_frame(0, 2, 8);
    check_drained("cont");
    n_cmp++;
    if (fdc_a != 3 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_stop: frame_done=%0d busy=%b, required 3 0", fdc_a, busy_a);
    end
  endtask

  task automatic test_short_line();
    apply_reset();
    pulse_arm(0);
    step(8);
    vsync = 1'b0;
    step(8);
    send_line(0, 0, 7, 1);
    send_line(0, 1, 8, 8);
    vsync = 1'b1;
    step(10);
    check_drained("short");
    n_cmp++;
    if (pix_a != 7 || errl_a !== 1'b1 || errf_a !== 1'b0 || fdc_a != 1) begin
      n_fail++;
      $display("FAIL short_line: pixels=%0d errl=%b errf=%b fd=%0d, required 7 1 0 1", pix_a, errl_a, errf_a, fdc_a);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    pulse_arm(0);
    send_frame(0, 3, 10);
    check_drained("overrun");
    n_cmp++;
    if (overrun_a || pix_a != 8) begin
      n_fail++;
      $display("FAIL overrun_addr: overrun_seen=%b pixels=%0d, required 0 and 8", overrun_a, pix_a);
    end
    n_cmp++;
    if (errl_a !== 1'b1 || errf_a !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_errs: errl=%b errf=%b, required 1 1", errl_a, errf_a);
    end
  endtask

  task automatic test_decim();
    apply_reset();
    pulse_arm(1);
    send_frame(1, 4, 8);
    check_drained("decim");
    n_cmp++;
    if (pix_b != 4 || fdc_b != 1 || pix_a != 0 || fdc_a != 0) begin
      n_fail++;
      $display("FAIL decim_counts: b_pixels=%0d b_fd=%0d a_pixels=%0d a_fd=%0d, required 4 1 0 0",
               pix_b, fdc_b, pix_a, fdc_a);
    end
    n_cmp++;
    if (errl_b !== 1'b0 || errf_b !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL decim_status: errl=%b errf=%b busy=%b, required 0 0 0", errl_b, errf_b, busy_b);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    pulse_arm(0);
    step(8);
    vsync = 1'b0;
    step(8);
    send_line(0, 0, 8, 1);
    href = 1'b1;
    step(4);
    send_bytes(0, 1, 4, 9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_cmp++;
    if (dout_a !== 32'd0 || pv_a !== 1'b0 || addr_a !== 19'd0 || fd_a !== 1'b0 ||
        busy_a !== 1'b0 || errl_a !== 1'b0 || errf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: dout=%h pv=%b addr=%0d fd=%b busy=%b errl=%b errf=%b, required all 0",
               dout_a, pv_a, addr_a, fd_a, busy_a, errl_a, errf_a);
    end
    href = 1'b0;
    step(6);
    vsync = 1'b1;
    step(10);
    check_drained("midreset");
    n_cmp++;
    if (fdc_a != 0 || pix_a != 6) begin
      n_fail++;
      $display("FAIL midreset_no_fd: frame_done=%0d pixels=%0d, required 0 and 6", fdc_a, pix_a);
    end
    pulse_arm(0);
    send_frame(0, 2, 8);
    check_drained("rearm");
    n_cmp++;
    if (fdc_a != 1 || pix_a != 14 || errl_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_frame: frame_done=%0d pixels=%0d errl=%b, required 1 14 0", fdc_a, pix_a, errl_a);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_short_line();
    test_overrun();
    test_decim();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
